// File: rtl/multicycle_control_sequencer.sv
// Multicycle sequencer for the 16-bit ISA: steps FETCH/DECODE/EXECUTE/MEM/HALT and owns PC, IR and Z/N.
// Datapath decode fields come combinationally from IR; bus strobes are registered on state entry.
module multicycle_control_sequencer #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    REG_SEL    = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_ready,
    input  logic [15:0]           mem_rdata,
    input  logic [ADDR_WIDTH-1:0] reg_a_data,
    input  logic [3:0]            status,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  mem_addr_sel,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           ir,
    output logic [REG_SEL-1:0]    da,
    output logic [REG_SEL-1:0]    aa,
    output logic [REG_SEL-1:0]    ba,
    output logic [3:0]            fs,
    output logic                  mb,
    output logic [ADDR_WIDTH-1:0] imm,
    output logic                  md,
    output logic                  rf_we,
    output logic                  halted,
    output logic                  illegal
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_ADI = 4'h6;
    localparam logic [3:0] OP_LDI = 4'h7;
    localparam logic [3:0] OP_LDR = 4'h8;
    localparam logic [3:0] OP_STR = 4'h9;
    localparam logic [3:0] OP_BRZ = 4'hA;
    localparam logic [3:0] OP_BRN = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_HALT
    } state_t;

    state_t     state;
    logic [3:0] opcode;
    logic       flag_z;
    logic       flag_n;
    logic       rf_we_exec;
    logic       is_alu;
    logic       is_ldi;
    logic       is_ldr;
    logic       is_str;
    logic       is_illegal;
    logic       branch_taken;
    logic       unused_status;

    function automatic logic [ADDR_WIDTH-1:0] sext8(input logic signed [7:0] v);
        return {{(ADDR_WIDTH-8){v[7]}}, v};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] zext8(input logic [7:0] v);
        return {{(ADDR_WIDTH-8){1'b0}}, v};
    endfunction

    assign opcode = ir[15:12];
    assign da     = ir[11 -: REG_SEL];
    assign aa     = ir[8 -: REG_SEL];
    assign ba     = ir[5 -: REG_SEL];
    assign md     = is_ldr;
    assign imm    = is_ldi ? zext8(ir[7:0]) : sext8(ir[7:0]);

    // V and C are not latched by this ISA
    assign unused_status = ^status[3:2];

    always_comb begin
        is_alu     = 1'b0;
        is_ldi     = 1'b0;
        is_ldr     = 1'b0;
        is_str     = 1'b0;
        is_illegal = 1'b0;
        fs         = 4'h0;
        mb         = 1'b0;
        case (opcode)
            OP_ADD: begin is_alu = 1'b1; fs = 4'h2; end
            OP_SUB: begin is_alu = 1'b1; fs = 4'h5; end
            OP_AND: begin is_alu = 1'b1; fs = 4'h8; end
            OP_OR:  begin is_alu = 1'b1; fs = 4'h9; end
            OP_XOR: begin is_alu = 1'b1; fs = 4'hA; end
            OP_ADI: begin is_alu = 1'b1; fs = 4'h2; mb = 1'b1; end
            OP_LDI: begin is_ldi = 1'b1; fs = 4'hC; mb = 1'b1; end
            OP_LDR: is_ldr = 1'b1;
            OP_STR: is_str = 1'b1;
            OP_NOP, OP_BRZ, OP_BRN, OP_JMP, OP_HLT: ;
            default: is_illegal = 1'b1;
        endcase
    end

    assign branch_taken = ((opcode == OP_BRZ) && flag_z) || ((opcode == OP_BRN) && flag_n);

    // The load writeback strobe must coincide with the memory's ready cycle, so it bypasses the register
    assign rf_we = rf_we_exec | ((state == S_MEM) && is_ldr && mem_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            ir           <= '0;
            flag_z       <= 1'b0;
            flag_n       <= 1'b0;
            illegal      <= 1'b0;
            mem_req      <= 1'b1;
            mem_addr_sel <= 1'b0;
            mem_we       <= 1'b0;
            rf_we_exec   <= 1'b0;
            halted       <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata;
                        pc      <= pc + PC_STEP;
                        mem_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_ldr || is_str) begin
                        mem_req      <= 1'b1;
                        mem_addr_sel <= 1'b1;
                        mem_we       <= is_str;
                        state        <= S_MEM;
                    end else if (opcode == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        rf_we_exec <= is_alu | is_ldi;
                        state      <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    rf_we_exec   <= 1'b0;
                    mem_req      <= 1'b1;
                    mem_addr_sel <= 1'b0;
                    state        <= S_FETCH;
                    if (is_alu) begin
                        flag_z <= status[0];
                        flag_n <= status[1];
                    end
                    if (branch_taken) begin
                        pc <= pc + sext8(ir[7:0]);
                    end else if (opcode == OP_JMP) begin
                        pc <= reg_a_data;
                    end
                    if (is_illegal) begin
                        illegal <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req      <= 1'b1;
                        mem_addr_sel <= 1'b0;
                        mem_we       <= 1'b0;
                        state        <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule
